// File: rtl/mem_fu_ctrl_pkg.sv
// Shared definitions for the memory FU controller: FSM state encoding,
// memory access size/sign codes understood by the memory FU, the default
// tag width and the packed operand bundle handed to the FU.
package mem_fu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Access size/sign codes (bhw) as decoded by the memory FU.
    localparam logic [2:0] BHW_B  = 3'b000;  // signed byte
    localparam logic [2:0] BHW_H  = 3'b001;  // signed halfword
    localparam logic [2:0] BHW_W  = 3'b010;  // word
    localparam logic [2:0] BHW_BU = 3'b100;  // unsigned byte
    localparam logic [2:0] BHW_HU = 3'b101;  // unsigned halfword

    localparam int TAG_W_DEF = 5;

    typedef struct packed {
        logic        mem_w;
        logic [2:0]  bhw;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
    } op_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: requester ptr wins if valid, else the other one.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is consumed.
// Ports: valid[1:0] request lines, ptr preferred index,
//        grant[1:0] one-hot (or zero) grant, gnt_idx index of the grant.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       gnt_idx
);

    logic other;

    assign other = ~ptr;

    always_comb begin
        grant   = 2'b00;
        gnt_idx = ptr;
        if (valid[ptr]) begin
            grant[ptr] = 1'b1;
            gnt_idx    = ptr;
        end else if (valid[other]) begin
            grant[other] = 1'b1;
            gnt_idx      = other;
        end
    end

endmodule

// File: rtl/mem_fu_ctrl.sv
// Arbitrates two load/store issue sources onto the single multi-cycle memory FU.
// Latency: grant -> fu_en 1 cycle, fu_en -> done_valid LATENCY cycles; issue interval LATENCY+2.
// Backpressure: req_ready only in IDLE; completion held in DONE until done_ready.
// Ports: clk/rst (sync, active-high); req_* per-requester operation with
//        valid/ready; fu_* registered operands and start pulse to the FU,
//        fu_mem_data load return; done_* tagged completion with valid/ready; busy.
module mem_fu_ctrl
    import mem_fu_ctrl_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int LATENCY = 2,
    parameter int TAG_W   = TAG_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_mem_w,
    input  logic [3*NREQ-1:0]    req_bhw,
    input  logic [32*NREQ-1:0]   req_rs1,
    input  logic [32*NREQ-1:0]   req_rs2,
    input  logic [32*NREQ-1:0]   req_imm,
    input  logic [NREQ*TAG_W-1:0] req_tag,
    output logic                 fu_en,
    output logic                 fu_mem_w,
    output logic [2:0]           fu_bhw,
    output logic [31:0]          fu_rs1_data,
    output logic [31:0]          fu_rs2_data,
    output logic [31:0]          fu_imm,
    input  logic [31:0]          fu_mem_data,
    output logic                 done_valid,
    input  logic                 done_ready,
    output logic [TAG_W-1:0]     done_tag,
    output logic                 done_src,
    output logic                 done_store,
    output logic [31:0]          done_data,
    output logic                 busy
);

    // cnt is 0 in the fu_en cycle, so the last EXEC cycle is LATENCY-1.
    localparam logic [2:0] CNT_LAST = 3'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q;
    logic              rr_ptr_q;
    logic [NREQ-1:0]   grant;
    logic              gnt_idx;
    logic              accept;
    logic              exec_last;
    op_t               op_sel, op_q;
    logic [TAG_W-1:0]  tag_sel, tag_q;
    logic              src_q;
    logic              fu_en_q;
    logic [31:0]       data_q;

    rr_arb2 u_arb (
        .valid   (req_valid),
        .ptr     (rr_ptr_q),
        .grant   (grant),
        .gnt_idx (gnt_idx)
    );

    // Ready is masked during reset so nothing is handed over while the
    // controller is being cleared.
    assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
    assign accept    = |req_ready;
    assign exec_last = (state_q == EXEC) && (cnt_q == CNT_LAST);

    always_comb begin
        op_sel.mem_w = gnt_idx ? req_mem_w[1]     : req_mem_w[0];
        op_sel.bhw   = gnt_idx ? req_bhw[5:3]     : req_bhw[2:0];
        op_sel.rs1   = gnt_idx ? req_rs1[63:32]   : req_rs1[31:0];
        op_sel.rs2   = gnt_idx ? req_rs2[63:32]   : req_rs2[31:0];
        op_sel.imm   = gnt_idx ? req_imm[63:32]   : req_imm[31:0];
        tag_sel      = gnt_idx ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)     state_d = EXEC;
            EXEC:    if (exec_last)  state_d = DONE;
            DONE:    if (done_ready) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= 1'b0;
            fu_en_q  <= 1'b0;
            op_q     <= '0;
            tag_q    <= '0;
            src_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            fu_en_q <= accept;
            if (accept) begin
                op_q     <= op_sel;
                tag_q    <= tag_sel;
                src_q    <= gnt_idx;
                rr_ptr_q <= ~gnt_idx;
                cnt_q    <= '0;
            end else if (state_q == EXEC) begin
                cnt_q <= cnt_q + 3'd1;
            end
            // Stores report zero so the write-back stage never sees stale bus data.
            if (exec_last) begin
                data_q <= op_q.mem_w ? 32'd0 : fu_mem_data;
            end
        end
    end

    assign fu_en       = fu_en_q;
    assign fu_mem_w    = op_q.mem_w;
    assign fu_bhw      = op_q.bhw;
    assign fu_rs1_data = op_q.rs1;
    assign fu_rs2_data = op_q.rs2;
    assign fu_imm      = op_q.imm;

    assign done_valid  = (state_q == DONE);
    assign done_tag    = tag_q;
    assign done_src    = src_q;
    assign done_store  = op_q.mem_w;
    assign done_data   = data_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_fu_ctrl.sv
// Bench for mem_fu_ctrl: three instances with LATENCY 2, 1 and 4, each with
// a small FU model that puts the load value on fu_mem_data only in the one
// cycle it must be sampled (random data otherwise).
module tb_mem_fu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid   [3];
    logic [1:0]  req_ready   [3];
    logic [1:0]  req_mem_w   [3];
    logic [5:0]  req_bhw     [3];
    logic [63:0] req_rs1     [3];
    logic [63:0] req_rs2     [3];
    logic [63:0] req_imm     [3];
    logic [9:0]  req_tag     [3];
    logic        fu_en       [3];
    logic        fu_mem_w    [3];
    logic [2:0]  fu_bhw      [3];
    logic [31:0] fu_rs1_data [3];
    logic [31:0] fu_rs2_data [3];
    logic [31:0] fu_imm      [3];
    logic [31:0] fu_mem_data [3];
    logic        done_valid  [3];
    logic        done_ready  [3];
    logic [4:0]  done_tag    [3];
    logic        done_src    [3];
    logic        done_store  [3];
    logic [31:0] done_data   [3];
    logic        busy        [3];
    logic [31:0] load_val    [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LATV = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        int k = 0;

        mem_fu_ctrl #(.NREQ(2), .LATENCY(LATV), .TAG_W(5)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_mem_w   (req_mem_w[g]),
            .req_bhw     (req_bhw[g]),
            .req_rs1     (req_rs1[g]),
            .req_rs2     (req_rs2[g]),
            .req_imm     (req_imm[g]),
            .req_tag     (req_tag[g]),
            .fu_en       (fu_en[g]),
            .fu_mem_w    (fu_mem_w[g]),
            .fu_bhw      (fu_bhw[g]),
            .fu_rs1_data (fu_rs1_data[g]),
            .fu_rs2_data (fu_rs2_data[g]),
            .fu_imm      (fu_imm[g]),
            .fu_mem_data (fu_mem_data[g]),
            .done_valid  (done_valid[g]),
            .done_ready  (done_ready[g]),
            .done_tag    (done_tag[g]),
            .done_src    (done_src[g]),
            .done_store  (done_store[g]),
            .done_data   (done_data[g]),
            .busy        (busy[g])
        );

        // k = 1 in the fu_en cycle; the value must be on the bus in cycle k == LATENCY
        // so that it is present at the edge LATENCY cycles after fu_en rose.
        always @(negedge clk) begin
            if (rst) k = 0;
            else if (fu_en[g]) k = 1;
            else if (k != 0 && k < 16) k = k + 1;
            fu_mem_data[g] = (k == LATV) ? load_val[g] : $urandom;
        end
    end

    function automatic int lat(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    endfunction

    task automatic clear_inputs();
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = '0; req_mem_w[d] = '0; req_bhw[d] = '0;
            req_rs1[d] = '0; req_rs2[d] = '0; req_imm[d] = '0; req_tag[d] = '0;
            done_ready[d] = 1'b0; load_val[d] = '0;
        end
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_op(input int d, input int i, input logic st, input logic [2:0] bhw,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic [4:0] tag);
        req_valid[d][i]        = 1'b1;
        req_mem_w[d][i]        = st;
        req_bhw[d][3*i +: 3]   = bhw;
        req_rs1[d][32*i +: 32] = rs1;
        req_rs2[d][32*i +: 32] = rs2;
        req_imm[d][32*i +: 32] = imm;
        req_tag[d][5*i +: 5]   = tag;
    endtask

    // Returns the number of negedges until done_valid is seen, -1 if never.
    task automatic wait_done(input int d, input int max, output int cyc);
        int c;
        c   = 0;
        cyc = -1;
        while (cyc < 0 && c < max) begin
            c++;
            @(negedge clk); #1;
            if (done_valid[d]) cyc = c;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 2'b11;
            req_rs1[d]   = {$urandom, $urandom};
            done_ready[d] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if ({req_ready[d], fu_en[d], fu_mem_w[d], fu_bhw[d], fu_rs1_data[d], fu_rs2_data[d],
                 fu_imm[d], done_valid[d], done_tag[d], done_src[d], done_store[d],
                 done_data[d], busy[d]} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs d=%0d: ready=%b fu_en=%b done_valid=%b busy=%b rs1=%h, want all zero",
                         d, req_ready[d], fu_en[d], done_valid[d], busy[d], fu_rs1_data[d]);
            end
        end
    endtask

    task automatic test_single_load();
        int cyc;
        apply_reset();
        load_val[0] = 32'hDEADBEEF;
        set_op(0, 0, 1'b0, 3'b010, 32'h100, $urandom, 32'h4, 5'd7);
        #1;
        n_checks++;
        if (req_ready[0] !== 2'b01) begin n_fail++; $display("FAIL load_ready: got %b want 01", req_ready[0]); end
        @(negedge clk); #1;
        n_checks++;
        if ({fu_en[0], fu_mem_w[0], fu_bhw[0], fu_rs1_data[0], fu_imm[0], busy[0], req_ready[0]} !==
            {1'b1, 1'b0, 3'b010, 32'h100, 32'h4, 1'b1, 2'b00}) begin
            n_fail++;
            $display("FAIL load_issue: fu_en=%b mem_w=%b bhw=%b rs1=%h imm=%h busy=%b ready=%b want 1 0 010 100 4 1 00",
                     fu_en[0], fu_mem_w[0], fu_bhw[0], fu_rs1_data[0], fu_imm[0], busy[0], req_ready[0]);
        end
        req_valid[0] = '0;
        wait_done(0, 12, cyc);
        n_checks++;
        if (cyc != 2) begin n_fail++; $display("FAIL load_latency: got %0d want 2", cyc); end
        n_checks++;
        if ({done_tag[0], done_src[0], done_store[0], done_data[0]} !== {5'd7, 1'b0, 1'b0, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL load_done: tag=%0d src=%b store=%b data=%h want 7 0 0 deadbeef",
                     done_tag[0], done_src[0], done_store[0], done_data[0]);
        end
        done_ready[0] = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({done_valid[0], busy[0]} !== 2'b00) begin
            n_fail++; $display("FAIL load_ack: done_valid=%b busy=%b want 0 0", done_valid[0], busy[0]);
        end
        done_ready[0] = 1'b0;
    endtask

    task automatic test_contention();
        int gi[$];
        int gc[$];
        int dt[$];
        logic [31:0] r0, r1;
        apply_reset();
        r0 = $urandom; r1 = $urandom;
        load_val[0] = $urandom;
        set_op(0, 0, 1'b0, 3'b010, r0, $urandom, $urandom, 5'd3);
        set_op(0, 1, 1'b0, 3'b000, r1, $urandom, $urandom, 5'd9);
        done_ready[0] = 1'b1;
        for (int c = 0; c < 60 && (gi.size() < 4 || dt.size() < 4); c++) begin
            #1;
            if (req_ready[0] != 2'b00) begin
                gi.push_back(req_ready[0] == 2'b10 ? 1 : 0);
                gc.push_back(c);
            end
            if (fu_en[0] && gi.size() > 0) begin
                n_checks++;
                if (fu_rs1_data[0] !== (gi[gi.size()-1] == 1 ? r1 : r0)) begin
                    n_fail++; $display("FAIL rr_operand: got %h want %h", fu_rs1_data[0],
                                       (gi[gi.size()-1] == 1 ? r1 : r0));
                end
            end
            if (done_valid[0]) dt.push_back(int'(done_tag[0]));
            @(negedge clk);
        end
        n_checks++;
        if (gi.size() < 4 || dt.size() < 4) begin
            n_fail++; $display("FAIL rr_count: grants=%0d dones=%0d want >=4 each", gi.size(), dt.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (gi[k] != k % 2) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, gi[k], k % 2); end
                n_checks++;
                if (dt[k] != ((k % 2) ? 9 : 3)) begin
                    n_fail++; $display("FAIL rr_tag[%0d]: got %0d want %0d", k, dt[k], (k % 2) ? 9 : 3);
                end
                if (k > 0) begin
                    n_checks++;
                    if (gc[k] - gc[k-1] != lat(0) + 2) begin
                        n_fail++; $display("FAIL rr_interval[%0d]: got %0d want %0d", k, gc[k] - gc[k-1], lat(0) + 2);
                    end
                end
            end
        end
        req_valid[0] = '0;
        done_ready[0] = 1'b0;
    endtask

    task automatic test_store();
        int cyc;
        logic [4:0] t;
        apply_reset();
        t = 5'($urandom);
        load_val[0] = $urandom | 32'h1;
        set_op(0, 1, 1'b1, 3'b010, $urandom, 32'h12345678, $urandom, t);
        #1;
        n_checks++;
        if (req_ready[0] !== 2'b10) begin n_fail++; $display("FAIL store_ready: got %b want 10", req_ready[0]); end
        @(negedge clk); #1;
        n_checks++;
        if ({fu_en[0], fu_mem_w[0], fu_rs2_data[0]} !== {1'b1, 1'b1, 32'h12345678}) begin
            n_fail++; $display("FAIL store_issue: fu_en=%b mem_w=%b rs2=%h want 1 1 12345678",
                               fu_en[0], fu_mem_w[0], fu_rs2_data[0]);
        end
        req_valid[0] = '0;
        wait_done(0, 12, cyc);
        n_checks++;
        if ({done_store[0], done_data[0], done_src[0], done_tag[0]} !== {1'b1, 32'd0, 1'b1, t}) begin
            n_fail++; $display("FAIL store_done: store=%b data=%h src=%b tag=%0d want 1 0 1 %0d (cyc %0d)",
                               done_store[0], done_data[0], done_src[0], done_tag[0], t, cyc);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [4:0] t;
        logic [31:0] v;
        apply_reset();
        t = 5'($urandom);
        v = $urandom;
        load_val[0] = v;
        set_op(0, 0, 1'b0, 3'b001, $urandom, $urandom, $urandom, t);
        @(negedge clk);
        req_valid[0] = '0;
        wait_done(0, 12, cyc);
        set_op(0, 0, 1'b0, 3'b010, $urandom, $urandom, $urandom, t + 5'd1);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if ({done_valid[0], done_tag[0], done_src[0], done_store[0], done_data[0], req_ready[0], busy[0]} !==
                {1'b1, t, 1'b0, 1'b0, v, 2'b00, 1'b1}) begin
                n_fail++;
                $display("FAIL hold[%0d]: valid=%b tag=%0d data=%h ready=%b busy=%b want 1 %0d %h 00 1",
                         c, done_valid[0], done_tag[0], done_data[0], req_ready[0], busy[0], t, v);
            end
            @(negedge clk);
        end
        done_ready[0] = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({done_valid[0], req_ready[0]} !== {1'b0, 2'b01}) begin
            n_fail++; $display("FAIL hold_release: done_valid=%b ready=%b want 0 01", done_valid[0], req_ready[0]);
        end
        done_ready[0] = 1'b0;
        req_valid[0] = '0;
    endtask

    task automatic test_reset_mid();
        logic seen;
        apply_reset();
        load_val[0] = $urandom;
        set_op(0, 0, 1'b0, 3'b010, $urandom, $urandom, $urandom, 5'd21);
        @(negedge clk);
        req_valid[0] = '0;
        #1;
        n_checks++;
        if (fu_en[0] !== 1'b1) begin n_fail++; $display("FAIL abort_setup: fu_en=%b want 1", fu_en[0]); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({fu_en[0], done_valid[0], busy[0]} !== 3'b000) begin
            n_fail++; $display("FAIL abort_idle: fu_en=%b done_valid=%b busy=%b want 000",
                               fu_en[0], done_valid[0], busy[0]);
        end
        seen = 1'b0;
        done_ready[0] = 1'b1;
        repeat (lat(0) + 4) begin
            @(negedge clk); #1;
            if (done_valid[0]) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got done_valid=1 want none"); end
        done_ready[0] = 1'b0;
        set_op(0, 0, 1'b0, 3'b010, $urandom, $urandom, $urandom, 5'd1);
        set_op(0, 1, 1'b0, 3'b010, $urandom, $urandom, $urandom, 5'd2);
        #1;
        n_checks++;
        if (req_ready[0] !== 2'b01) begin n_fail++; $display("FAIL abort_rr_ptr: got %b want 01", req_ready[0]); end
        req_valid[0] = '0;
    endtask

    task automatic test_latency();
        int cyc;
        for (int d = 1; d < 3; d++) begin
            apply_reset();
            load_val[d] = 32'hA5A5A5A5;
            set_op(d, 0, 1'b0, 3'b010, $urandom, $urandom, $urandom, 5'd12);
            @(negedge clk); #1;
            req_valid[d] = '0;
            n_checks++;
            if (fu_en[d] !== 1'b1) begin n_fail++; $display("FAIL lat_issue d=%0d: fu_en=%b want 1", d, fu_en[d]); end
            wait_done(d, 12, cyc);
            n_checks++;
            if (cyc != lat(d)) begin n_fail++; $display("FAIL lat_cycles d=%0d: got %0d want %0d", d, cyc, lat(d)); end
            n_checks++;
            if (done_data[d] !== 32'hA5A5A5A5) begin
                n_fail++; $display("FAIL lat_data d=%0d: got %h want a5a5a5a5", d, done_data[d]);
            end
        end
    endtask

    // Reference: one operation at a time; an accepted op shows fu_en one cycle
    // later, completes LATENCY cycles after that and stays until acknowledged.
    task automatic test_random();
        for (int d = 0; d < 3; d++) begin
            bit          m_busy;
            int          m_age;
            int          m_ptr;
            int          idx;
            bit [1:0]    hold;
            logic [1:0]  exp_rdy;
            logic        e_st;
            logic [2:0]  e_bhw;
            logic [31:0] e_rs1, e_rs2, e_imm, e_data;
            logic [4:0]  e_tag;
            int          e_src;
            apply_reset();
            m_busy = 0; m_age = 0; m_ptr = 0; hold = 2'b00;
            e_st = 0; e_bhw = 0; e_rs1 = 0; e_rs2 = 0; e_imm = 0; e_data = 0; e_tag = 0; e_src = 0;
            for (int c = 0; c < 200; c++) begin
                for (int i = 0; i < 2; i++) begin
                    if (!hold[i]) begin
                        if ($urandom % 3 == 0) begin
                            set_op(d, i, 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
                            hold[i] = 1'b1;
                        end else begin
                            req_valid[d][i] = 1'b0;
                        end
                    end
                end
                done_ready[d] = 1'($urandom);
                #1;
                exp_rdy = 2'b00;
                if (!m_busy) begin
                    if (req_valid[d][m_ptr]) exp_rdy[m_ptr] = 1'b1;
                    else if (req_valid[d][1 - m_ptr]) exp_rdy[1 - m_ptr] = 1'b1;
                end
                n_checks++;
                if ({req_ready[d], busy[d], done_valid[d], fu_en[d]} !==
                    {exp_rdy, m_busy, (m_busy && m_age >= lat(d) + 1), (m_busy && m_age == 1)}) begin
                    n_fail++;
                    $display("FAIL rnd_ctrl d=%0d c=%0d: ready=%b busy=%b dv=%b fu_en=%b want %b %b %b %b", d, c,
                             req_ready[d], busy[d], done_valid[d], fu_en[d], exp_rdy, m_busy,
                             (m_busy && m_age >= lat(d) + 1), (m_busy && m_age == 1));
                end
                if (m_busy && m_age == 1) begin
                    n_checks++;
                    if ({fu_mem_w[d], fu_bhw[d], fu_rs1_data[d], fu_rs2_data[d], fu_imm[d]} !==
                        {e_st, e_bhw, e_rs1, e_rs2, e_imm}) begin
                        n_fail++; $display("FAIL rnd_operands d=%0d c=%0d: rs1=%h rs2=%h imm=%h want %h %h %h",
                                           d, c, fu_rs1_data[d], fu_rs2_data[d], fu_imm[d], e_rs1, e_rs2, e_imm);
                    end
                end
                if (m_busy && m_age >= lat(d) + 1) begin
                    n_checks++;
                    if ({done_tag[d], done_src[d], done_store[d], done_data[d]} !==
                        {e_tag, 1'(e_src), e_st, e_data}) begin
                        n_fail++; $display("FAIL rnd_done d=%0d c=%0d: tag=%0d src=%b st=%b data=%h want %0d %0d %b %h",
                                           d, c, done_tag[d], done_src[d], done_store[d], done_data[d],
                                           e_tag, e_src, e_st, e_data);
                    end
                end
                if (!m_busy && exp_rdy != 2'b00) begin
                    idx    = exp_rdy[1] ? 1 : 0;
                    e_src  = idx;
                    e_st   = req_mem_w[d][idx];
                    e_bhw  = req_bhw[d][3*idx +: 3];
                    e_rs1  = req_rs1[d][32*idx +: 32];
                    e_rs2  = req_rs2[d][32*idx +: 32];
                    e_imm  = req_imm[d][32*idx +: 32];
                    e_tag  = req_tag[d][5*idx +: 5];
                    load_val[d] = $urandom;
                    e_data = e_st ? 32'd0 : load_val[d];
                    m_busy = 1; m_age = 1; m_ptr = 1 - idx;
                    hold[idx] = 1'b0;
                end else if (m_busy) begin
                    if (m_age >= lat(d) + 1 && done_ready[d]) m_busy = 0;
                    else m_age++;
                end
                @(negedge clk);
            end
            clear_inputs();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_load();
        test_contention();
        test_store();
        test_backpressure();
        test_reset_mid();
        test_latency();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
